// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: 1 start, DATA_BITS data (LSB first), 1 stop, no parity.
// Consumes the baud generator's one-cycle sampling strobe; reports each word with a done pulse.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICK   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_s_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_dout,
    output logic                 o_rx_done_tick,
    output logic                 o_frame_err
);

    // s must also reach 15 inside data bits, so never narrower than 4 bits
    localparam int S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int N_W = ($clog2(DATA_BITS) > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_n;
    logic [S_W-1:0]       s, s_n;
    logic [N_W-1:0]       n, n_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic [DATA_BITS-1:0] dout_n;
    logic                 err_n, done_n;
    logic                 rx_meta, rx_s;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            s              <= '0;
            n              <= '0;
            sh             <= '0;
            o_dout         <= '0;
            o_frame_err    <= 1'b0;
            o_rx_done_tick <= 1'b0;
        end else begin
            state          <= state_n;
            s              <= s_n;
            n              <= n_n;
            sh             <= sh_n;
            o_dout         <= dout_n;
            o_frame_err    <= err_n;
            o_rx_done_tick <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        sh_n    = sh;
        dout_n  = o_dout;
        err_n   = o_frame_err;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                if (i_s_tick) begin
                    if (s == S_W'(7)) begin
                        // line back high at mid start bit: a glitch, not a frame
                        if (!rx_s) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (i_s_tick) begin
                    if (s == S_W'(15)) begin
                        s_n  = '0;
                        sh_n = {rx_s, sh[DATA_BITS-1:1]};
                        if (n == N_W'(DATA_BITS - 1))
                            state_n = STOP;
                        else
                            n_n = n + N_W'(1);
                    end else begin
                        s_n = s + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (i_s_tick) begin
                    if (s == S_W'(SB_TICK - 1)) begin
                        state_n = IDLE;
                        dout_n  = sh;
                        err_n   = ~rx_s;
                        done_n  = 1'b1;
                    end else begin
                        s_n = s + S_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
